// File: rtl/button_conditioner.sv
// Per-channel synchroniser, debouncer and press-pulse generator
// for the mole push-buttons feeding the board controller.
module button_conditioner #(
  parameter int N_BUTTONS       = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [N_BUTTONS-1:0] button_raw,
  output logic [N_BUTTONS-1:0] button,
  output logic [N_BUTTONS-1:0] button_level
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BUTTONS-1:0] s1_q, s2_q;
  logic [N_BUTTONS-1:0] level_q, level_d;
  logic [N_BUTTONS-1:0] pulse_q, pulse_d;
  logic [CNT_W-1:0]     cnt_q [N_BUTTONS];
  logic [CNT_W-1:0]     cnt_d [N_BUTTONS];

  // Any return to the accepted level discards the partial count.
  always_comb begin
    level_d = level_q;
    pulse_d = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = s2_q[i];
          pulse_d[i] = enable & s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      level_q <= '0;
      pulse_q <= '0;
      for (int i = 0; i < N_BUTTONS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q    <= button_raw;
      s2_q    <= s1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < N_BUTTONS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign button       = pulse_q;
  assign button_level = level_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a cycle-level
// reference model of sync delay, run-length debounce and pulse gating.
module tb_button_conditioner;

  localparam int N   = 5;
  localparam int DEB = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b1;
  logic [N-1:0] button_raw = '0;
  logic [N-1:0] button;
  logic [N-1:0] button_level;

  button_conditioner #(
    .N_BUTTONS      (N),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .button_raw  (button_raw),
    .button      (button),
    .button_level(button_level)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int bad = 0;
  int pcnt [N];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: raw is seen two edges late; a level change is taken
  // after DEB consecutive edges of disagreement with the held level.
  logic [N-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_pulse = '0;
  int           run [N];
  bit           chk_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pulse = '0;
      for (int i = 0; i < N; i++) run[i] = 0;
      chk_on = 1'b1;
    end else begin
      for (int i = 0; i < N; i++) begin
        m_pulse[i] = 1'b0;
        if (m_s2[i] != m_lvl[i]) run[i] = run[i] + 1;
        else run[i] = 0;
        if (run[i] == DEB) begin
          m_lvl[i]   = m_s2[i];
          m_pulse[i] = enable & m_s2[i];
          run[i]     = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = button_raw;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_pulse", 32'(button), 32'(m_pulse));
      check("model_level", 32'(button_level), 32'(m_lvl));
      for (int i = 0; i < N; i++) pcnt[i] += int'(button[i]);
    end
  end

  task automatic measure(input int ch, input bit lvl, input logic val,
                         output int n);
    logic s;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      s = lvl ? button_level[ch] : button[ch];
    end while (s !== val && n < 20);
  endtask

  initial begin
    int n;
    int p;
    for (int i = 0; i < N; i++) pcnt[i] = 0;

    repeat (2) @(negedge clk);
    check("rst_button", 32'(button), 32'h0);
    check("rst_level", 32'(button_level), 32'h0);
    rst = 1'b0;

    button_raw[0] = 1'b1;
    measure(0, 1'b0, 1'b1, n);
    check("press_latency", n, 6);
    @(negedge clk);
    check("press_one_cycle", 32'(button[0]), 32'h0);
    check("press_level", 32'(button_level[0]), 32'h1);
    button_raw[0] = 1'b0;
    repeat (8) @(negedge clk);

    p = pcnt[2];
    button_raw[2] = 1'b1; repeat (2) @(negedge clk);
    button_raw[2] = 1'b0; repeat (2) @(negedge clk);
    button_raw[2] = 1'b1; repeat (2) @(negedge clk);
    button_raw[2] = 1'b0; repeat (2) @(negedge clk);
    check("bounce_no_pulse", pcnt[2] - p, 0);
    button_raw[2] = 1'b1;
    measure(2, 1'b0, 1'b1, n);
    check("bounce_latency", n, 6);
    repeat (4) @(negedge clk);
    button_raw[2] = 1'b0; repeat (3) @(negedge clk);
    button_raw[2] = 1'b1; repeat (8) @(negedge clk);
    check("glitch_level", 32'(button_level[2]), 32'h1);
    check("bounce_pulses", pcnt[2] - p, 1);
    button_raw[2] = 1'b0;
    repeat (8) @(negedge clk);

    button_raw = 5'b10101;
    measure(0, 1'b0, 1'b1, n);
    check("simul_latency", n, 6);
    check("simul_button", 32'(button), 32'h15);
    @(negedge clk);
    check("simul_after", 32'(button), 32'h0);
    button_raw = '0;
    repeat (8) @(negedge clk);

    enable = 1'b0;
    p = pcnt[1];
    button_raw[1] = 1'b1; repeat (8) @(negedge clk);
    enable = 1'b1; repeat (4) @(negedge clk);
    check("gate_no_pulse", pcnt[1] - p, 0);
    check("gate_level", 32'(button_level[1]), 32'h1);
    button_raw[1] = 1'b0; repeat (8) @(negedge clk);
    check("gate_release", 32'(button_level[1]), 32'h0);
    button_raw[1] = 1'b1;
    measure(1, 1'b0, 1'b1, n);
    check("gate_repress_latency", n, 6);
    repeat (2) @(negedge clk);
    check("gate_repress_pulses", pcnt[1] - p, 1);
    button_raw[1] = 1'b0;
    repeat (8) @(negedge clk);

    p = pcnt[3];
    button_raw[3] = 1'b1; repeat (50) @(negedge clk);
    button_raw[3] = 1'b0;
    measure(3, 1'b1, 1'b0, n);
    check("release_latency", n, 6);
    repeat (4) @(negedge clk);
    check("hold_pulses", pcnt[3] - p, 1);

    p = pcnt[4];
    button_raw[4] = 1'b1; repeat (4) @(negedge clk);
    rst = 1'b1; @(negedge clk);
    check("midrst_button", 32'(button), 32'h0);
    check("midrst_level", 32'(button_level), 32'h0);
    rst = 1'b0;
    measure(4, 1'b0, 1'b1, n);
    check("midrst_latency", n, 6);
    repeat (2) @(negedge clk);
    check("midrst_pulses", pcnt[4] - p, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions the raw, asynchronous, bouncing mole push-buttons into clean one-cycle, active-high press pulses.
- Sits directly upstream of the board controller and drives its `button[4:0]` input.
- Each button has its own 2-flop synchroniser, its own debounce counter and a rising-edge pulse generator.
- Pulses are gated by `enable` (global_state == START), so presses outside gameplay never reach the board.

Parameters:
- N_BUTTONS, 5, number of independent button channels.
- DEBOUNCE_CYCLES, 1_000_000, consecutive cycles a changed input must hold before it is accepted (10 ms at 100 MHz); legal range 2..2^CNT_W-1.
- CNT_W, 20, width of each per-channel debounce counter.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  active high; when low, `button` is forced to 0.
- button_raw  input  N_BUTTONS  raw pad inputs, asynchronous, active high while pressed.
- button  output  N_BUTTONS  active-high one-cycle press pulse per channel; feeds the board.
- button_level  output  N_BUTTONS  debounced steady state per channel.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous and active-high (rst), sampled on posedge clk only.
  - While rst=1: sync flops=0, counters=0, button_level=0, button=0.
- Synchroniser:
  - s1[i] <= button_raw[i]; s2[i] <= s1[i].
  - Only s2 is used downstream; no other logic samples button_raw.
- Debounce, per channel, evaluated every clk:
  - s2[i]==button_level[i]: cnt[i] <= 0.
  - s2[i]!=button_level[i] and cnt[i]!=DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - s2[i]!=button_level[i] and cnt[i]==DEBOUNCE_CYCLES-1: button_level[i] <= s2[i]; cnt[i] <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES returns cnt to 0; there is no partial credit carried over.
- Pulse generation:
  - button[i] <= enable & accept[i] & s2[i], where accept[i] is the third debounce case above. This is registered, so the pulse is coincident with button_level[i] rising.
  - button[i] is never high for two consecutive cycles.
  - Release (accepted 1->0 change) produces no pulse.
  - Holding a button produces exactly one pulse, with no auto-repeat.
- Latency:
  - Raw input goes high and is stable before edge 0 (captured in s1).
  - button and button_level go high after edge DEBOUNCE_CYCLES+1.
  - Total: DEBOUNCE_CYCLES+2 clk edges.
- Enable:
  - Only gates the pulse; debounce state keeps tracking while enable=0.
  - A press accepted while enable=0 is lost. It does not fire later when enable rises.
- Channels are fully independent; simultaneous accepts on several channels give simultaneous pulses.
- Counter width: cnt never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.
- Reset mid-operation:
  - All state clears.
  - A button still held after rst deasserts is treated as a new press and pulses DEBOUNCE_CYCLES+2 edges after rst is first sampled low.

Test Plan (DEBOUNCE_CYCLES=4 for simulation):
- Clean press: rst 2 cycles, enable=1, button_raw[0] 0->1 held -> button[0]=1 exactly one cycle, 6 edges after the first edge sampling raw=1. button_level[0]=1 from the same cycle onwards.
- Bounce rejection: button_raw[2] toggles 1,0,1,0 every 2 cycles, then holds 1 -> no pulse during toggling; a single pulse 6 edges after the final rise. Release glitch of 3 cycles -> button_level stays 1.
- Simultaneous presses: button_raw=5'b10101 in the same cycle -> button=5'b10101 for one cycle, then 5'b00000.
- Enable gating: enable=0, press button_raw[1] and hold until accepted, then enable=1 while held -> button stays 0 throughout; button_level[1]=1. Release and re-press with enable=1 -> one pulse.
- Hold and release: hold button_raw[3] for 50 cycles, then release -> exactly one pulse total; button_level[3] returns to 0 six edges after release; no pulse on release.
- Reset mid-press: press button_raw[4], assert rst for 1 cycle at debounce count 2, keep raw held -> all outputs 0 during rst; one pulse 6 edges after rst deasserts.
